// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch and the load/store buffer.
// Reads assemble little-endian words (done n+2 cycles after grant); writes serialise (done n+1) and stall on a full UART.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  roll_back,
  input  logic                  if_fetch_start,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_finish,
  output logic [31:0]           if_instr,
  output logic                  is_idle,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_size,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic OWN_IF = 1'b0;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] base_q, base_d, mem_a_q, mem_a_d, next_a;
  logic [31:0]           wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0]           if_instr_q, if_instr_d, lsb_rdata_q, lsb_rdata_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  owner_q, owner_d, last_grant_q, last_grant_d;
  logic                  wr_q, wr_d, if_finish_q, if_finish_d, lsb_done_q, lsb_done_d;
  logic                  req_if, grant_lsb, grant_if, io_stall;

  function automatic logic [2:0] size_len(input logic [1:0] s);
    case (s)
      2'd0:    size_len = 3'd1;
      2'd1:    size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0: byte_sel = w[7:0];
      2'd1: byte_sel = w[15:8];
      2'd2: byte_sel = w[23:16];
      2'd3: byte_sel = w[31:24];
    endcase
  endfunction

  // A flushed fetch never competes; on contention the loser of the previous grant wins.
  assign req_if    = if_fetch_start && !roll_back;
  assign grant_lsb = lsb_req && (!req_if || last_grant_q == OWN_IF);
  assign grant_if  = req_if && !grant_lsb;
  assign io_stall  = (state_q == WRITE) && (base_q[17:16] == 2'b11) && io_buffer_full;
  assign cnt_inc   = cnt_q + 3'd1;
  assign next_a    = base_q + ADDR_WIDTH'(cnt_inc);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        IDLE:    if (grant_lsb)     state_d = lsb_wr ? WRITE : READ;
                 else if (grant_if) state_d = READ;
        READ:    if (roll_back || cnt_q == len_q) state_d = IDLE;
        WRITE:   if (!io_stall && cnt_inc == len_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // In READ, cnt runs one past the last address: byte k arrives while cnt == k+1.
  always_comb begin
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    mem_a_d      = mem_a_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    if_instr_d   = if_instr_q;
    lsb_rdata_d  = lsb_rdata_q;
    mem_dout_d   = mem_dout_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    if_finish_d  = if_finish_q;
    lsb_done_d   = lsb_done_q;
    if (rdy_in) begin
      if_finish_d = 1'b0;
      lsb_done_d  = 1'b0;
      case (state_q)
        IDLE: if (grant_lsb || grant_if) begin
          cnt_d        = 3'd0;
          buf_d        = 32'd0;
          owner_d      = grant_lsb;
          last_grant_d = grant_lsb;
          base_d       = grant_lsb ? lsb_addr : if_pc;
          mem_a_d      = grant_lsb ? lsb_addr : if_pc;
          len_d        = grant_lsb ? size_len(lsb_size) : 3'd4;
          if (grant_lsb && lsb_wr) begin
            wr_d       = 1'b1;
            wdata_d    = lsb_wdata;
            mem_dout_d = lsb_wdata[7:0];
          end
        end
        READ: if (roll_back) begin
          cnt_d = 3'd0;
        end else begin
          case (cnt_q)
            3'd1:    buf_d[7:0]   = mem_din;
            3'd2:    buf_d[15:8]  = mem_din;
            3'd3:    buf_d[23:16] = mem_din;
            3'd4:    buf_d[31:24] = mem_din;
            default: ;
          endcase
          if (cnt_q == len_q) begin
            cnt_d = 3'd0;
            if (owner_q == OWN_IF) begin
              if_instr_d  = buf_d;
              if_finish_d = 1'b1;
            end else begin
              lsb_rdata_d = buf_d;
              lsb_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc != len_q) mem_a_d = next_a;
          end
        end
        WRITE: if (!io_stall) begin
          if (cnt_inc == len_q) begin
            cnt_d      = 3'd0;
            wr_d       = 1'b0;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = next_a;
            mem_dout_d = byte_sel(wdata_q, cnt_inc[1:0]);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0; len_q <= '0; base_q <= '0; mem_a_q <= '0; wdata_q <= '0; buf_q <= '0;
      if_instr_q <= '0; lsb_rdata_q <= '0; mem_dout_q <= '0; owner_q <= OWN_IF;
      last_grant_q <= OWN_IF; wr_q <= 1'b0; if_finish_q <= 1'b0; lsb_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; len_q <= len_d; base_q <= base_d; mem_a_q <= mem_a_d; wdata_q <= wdata_d;
      buf_q <= buf_d; if_instr_q <= if_instr_d; lsb_rdata_q <= lsb_rdata_d; mem_dout_q <= mem_dout_d;
      owner_q <= owner_d; last_grant_q <= last_grant_d; wr_q <= wr_d;
      if_finish_q <= if_finish_d; lsb_done_q <= lsb_done_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = wr_q && rdy_in && !io_stall;
  assign if_finish = if_finish_q;
  assign if_instr  = if_instr_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;
  assign is_idle   = (state_q == IDLE) && !(rdy_in && (grant_lsb || grant_if));
endmodule
